// File: rtl/frame_ber_monitor.sv
// Frame-level bit-error-rate monitor.
// Tracks frame lock with a HUNT/CONFIRM/LOCKED/FLYWHEEL state machine driven by
// per-frame error counts. While locked, it accumulates total bit errors and
// errored-frame counts over a window of WIN frames and publishes the totals
// when each window completes.
//
// Handshake: Frame_Valid is a one-cycle strobe with no back-pressure. Every
// cycle with Frame_Valid=1 carries exactly one frame's Error_Count. Cycles
// without the strobe leave all state and outputs unchanged, except Win_Done,
// which is a one-cycle pulse.
module frame_ber_monitor #(
    parameter int FL      = 104,
    parameter int GOOD_TH = 3,
    parameter int N_GOOD  = 4,
    parameter int N_BAD   = 3,
    parameter int WIN     = 64
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        nClear,
    input  logic        Frame_Valid,
    input  logic [6:0]  Error_Count,
    output logic        Lock,
    output logic [1:0]  Lock_State,
    output logic [12:0] Win_Errors,
    output logic [6:0]  Win_Frame_Errors,
    output logic        Win_Done
);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        CONFIRM  = 2'd1,
        LOCKED   = 2'd2,
        FLYWHEEL = 2'd3
    } state_t;

    localparam logic [6:0] FL_C       = 7'(FL);
    localparam logic [6:0] GOOD_TH_C  = 7'(GOOD_TH);
    localparam logic [3:0] N_GOOD_C   = 4'(N_GOOD);
    localparam logic [3:0] N_BAD_C    = 4'(N_BAD);
    localparam logic [6:0] WIN_LAST_C = 7'(WIN - 1);

    state_t      state_q;
    logic [3:0]  run_q;
    logic [6:0]  win_cnt_q;
    logic [12:0] acc_err_q;
    logic [6:0]  acc_ferr_q;
    logic [12:0] win_err_q;
    logic [6:0]  win_ferr_q;
    logic        win_done_q;

    logic        frame_bad;
    logic        locked;
    logic [3:0]  run_inc;
    logic        hunt_entry;
    logic        win_last;
    logic [6:0]  win_cnt_d;
    logic [12:0] acc_err_d;
    logic [6:0]  acc_ferr_d;

    // Frame classification, running sums and the "dropping into HUNT" condition.
    always_comb begin
        frame_bad  = (Error_Count > GOOD_TH_C) || (Error_Count > FL_C);
        locked     = (state_q == LOCKED) || (state_q == FLYWHEEL);
        run_inc    = run_q + 4'd1;
        hunt_entry = Frame_Valid && frame_bad &&
                     ((state_q == CONFIRM) ||
                      ((state_q == FLYWHEEL) && (run_inc == N_BAD_C)));
        win_last   = (win_cnt_q == WIN_LAST_C);
        win_cnt_d  = win_cnt_q + 7'd1;
        acc_err_d  = acc_err_q + {6'd0, Error_Count};
        acc_ferr_d = acc_ferr_q + {6'd0, (Error_Count != 7'd0)};
    end

    // Lock state machine: run_q counts consecutive good frames in CONFIRM and
    // consecutive bad frames in FLYWHEEL.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= HUNT;
            run_q   <= 4'd0;
        end else if (!nClear) begin
            state_q <= HUNT;
            run_q   <= 4'd0;
        end else if (Frame_Valid) begin
            case (state_q)
                HUNT: begin
                    if (!frame_bad) begin
                        state_q <= CONFIRM;
                        run_q   <= 4'd1;
                    end
                end
                CONFIRM: begin
                    if (frame_bad) begin
                        state_q <= HUNT;
                        run_q   <= 4'd0;
                    end else if (run_inc == N_GOOD_C) begin
                        state_q <= LOCKED;
                        run_q   <= 4'd0;
                    end else begin
                        run_q   <= run_inc;
                    end
                end
                LOCKED: begin
                    if (frame_bad) begin
                        state_q <= FLYWHEEL;
                        run_q   <= 4'd1;
                    end
                end
                FLYWHEEL: begin
                    if (!frame_bad) begin
                        state_q <= LOCKED;
                        run_q   <= 4'd0;
                    end else if (run_inc == N_BAD_C) begin
                        state_q <= HUNT;
                        run_q   <= 4'd0;
                    end else begin
                        run_q   <= run_inc;
                    end
                end
                default: begin
                    state_q <= HUNT;
                    run_q   <= 4'd0;
                end
            endcase
        end
    end

    // Window accumulation while locked. The frame that drops lock is still
    // counted and may complete a window; the partial window is then discarded.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            win_cnt_q  <= 7'd0;
            acc_err_q  <= 13'd0;
            acc_ferr_q <= 7'd0;
            win_err_q  <= 13'd0;
            win_ferr_q <= 7'd0;
            win_done_q <= 1'b0;
        end else if (!nClear) begin
            win_cnt_q  <= 7'd0;
            acc_err_q  <= 13'd0;
            acc_ferr_q <= 7'd0;
            win_err_q  <= 13'd0;
            win_ferr_q <= 7'd0;
            win_done_q <= 1'b0;
        end else begin
            win_done_q <= 1'b0;
            if (Frame_Valid && locked) begin
                if (win_last) begin
                    win_err_q  <= acc_err_d;
                    win_ferr_q <= acc_ferr_d;
                    win_done_q <= 1'b1;
                    win_cnt_q  <= 7'd0;
                    acc_err_q  <= 13'd0;
                    acc_ferr_q <= 7'd0;
                end else begin
                    win_cnt_q  <= win_cnt_d;
                    acc_err_q  <= acc_err_d;
                    acc_ferr_q <= acc_ferr_d;
                end
            end
            if (hunt_entry) begin
                win_cnt_q  <= 7'd0;
                acc_err_q  <= 13'd0;
                acc_ferr_q <= 7'd0;
            end
        end
    end

    assign Lock             = locked;
    assign Lock_State       = state_q;
    assign Win_Errors       = win_err_q;
    assign Win_Frame_Errors = win_ferr_q;
    assign Win_Done         = win_done_q;

endmodule

// File: tb/tb_frame_ber_monitor.sv
// Self-checking bench for frame_ber_monitor (GOOD_TH=3, N_GOOD=4, N_BAD=3, WIN=8).
module tb_frame_ber_monitor;

  localparam int FL      = 104;
  localparam int GOOD_TH = 3;
  localparam int N_GOOD  = 4;
  localparam int N_BAD   = 3;
  localparam int WIN     = 8;

  logic        clock;
  logic        n_reset;
  logic        n_clear;
  logic        frame_valid;
  logic [6:0]  error_count;
  logic        lock;
  logic [1:0]  lock_state;
  logic [12:0] win_errors;
  logic [6:0]  win_frame_errors;
  logic        win_done;

  int n_checks;
  int n_fail;

  // expected {state[1:0], lock, done, win_errors[12:0], win_frame_errors[6:0]}
  logic [23:0] exp_q[$];

  // reference model state
  int m_state, m_run, m_wcnt, m_acc, m_accf, m_werr, m_wferr, m_done;

  frame_ber_monitor #(
    .FL(FL), .GOOD_TH(GOOD_TH), .N_GOOD(N_GOOD), .N_BAD(N_BAD), .WIN(WIN)
  ) dut (
    .Clock(clock),
    .nReset(n_reset),
    .nClear(n_clear),
    .Frame_Valid(frame_valid),
    .Error_Count(error_count),
    .Lock(lock),
    .Lock_State(lock_state),
    .Win_Errors(win_errors),
    .Win_Frame_Errors(win_frame_errors),
    .Win_Done(win_done)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_reset();
    m_state = 0; m_run = 0; m_wcnt = 0; m_acc = 0; m_accf = 0;
    m_werr = 0; m_wferr = 0; m_done = 0;
  endfunction

  function automatic logic [23:0] model_vec();
    logic [23:0] v;
    v = {2'(m_state), (m_state >= 2), 1'(m_done), 13'(m_werr), 7'(m_wferr)};
    return v;
  endfunction

  function automatic void model_step(input int c);
    bit was_lock;
    bit bad;
    was_lock = (m_state >= 2);
    bad = (c > GOOD_TH) || (c > FL);
    m_done = 0;
    if (was_lock) begin
      m_acc += c;
      m_accf += (c != 0) ? 1 : 0;
      m_wcnt++;
      if (m_wcnt == WIN) begin
        m_werr = m_acc; m_wferr = m_accf; m_done = 1;
        m_acc = 0; m_accf = 0; m_wcnt = 0;
      end
    end
    case (m_state)
      0: if (!bad) begin m_state = 1; m_run = 1; end
      1: if (bad) begin
           m_state = 0; m_run = 0;
         end else begin
           m_run++;
           if (m_run == N_GOOD) begin m_state = 2; m_run = 0; end
         end
      2: if (bad) begin m_state = 3; m_run = 1; end
      default: if (bad) begin
           m_run++;
           if (m_run == N_BAD) begin
             m_state = 0; m_run = 0; m_acc = 0; m_accf = 0; m_wcnt = 0;
           end
         end else begin
           m_state = 2; m_run = 0;
         end
    endcase
  endfunction

  // driver: one strobed frame, scoreboard compare one cycle later
  task automatic drive_frame(input logic [6:0] c, input string tag);
    logic [23:0] exp;
    logic [23:0] obs;
    @(negedge clock);
    frame_valid = 1'b1;
    error_count = c;
    model_step(int'(c));
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1;
    frame_valid = 1'b0;
    exp = exp_q.pop_front();
    obs = {lock_state, lock, win_done, win_errors, win_frame_errors};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d lock=%0b done=%0b werr=%0d wferr=%0d, expected state=%0d lock=%0b done=%0b werr=%0d wferr=%0d",
               tag, obs[23:22], obs[21], obs[20], obs[19:7], obs[6:0],
               exp[23:22], exp[21], exp[20], exp[19:7], exp[6:0]);
    end
  endtask

  // driver: idle cycles, outputs must hold and Win_Done must be low
  task automatic idle_cycles(input int n, input string tag);
    logic [23:0] exp;
    logic [23:0] obs;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      frame_valid = 1'b0;
      error_count = 7'($urandom_range(0, 127));
      m_done = 0;
      exp_q.push_back(model_vec());
      @(posedge clock);
      #1;
      exp = exp_q.pop_front();
      obs = {lock_state, lock, win_done, win_errors, win_frame_errors};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s: got state=%0d lock=%0b done=%0b werr=%0d wferr=%0d, expected state=%0d lock=%0b done=%0b werr=%0d wferr=%0d",
                 tag, obs[23:22], obs[21], obs[20], obs[19:7], obs[6:0],
                 exp[23:22], exp[21], exp[20], exp[19:7], exp[6:0]);
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    n_reset = 1'b0;
    #3;
    n_reset = 1'b1;
    model_reset();
  endtask

  task automatic lock_up();
    reset_dut();
    for (int i = 0; i < N_GOOD; i++) drive_frame(7'd0, "lock_up");
  endtask

  task automatic test_reset();
    frame_valid = 1'b0;
    error_count = 7'd0;
    n_clear = 1'b1;
    n_reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({lock_state, lock, win_done, win_errors, win_frame_errors} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d lock=%0b done=%0b werr=%0d wferr=%0d, expected all 0",
               lock_state, lock, win_done, win_errors, win_frame_errors);
    end
    @(negedge clock);
    n_reset = 1'b1;
    idle_cycles(2, "reset_hold");
  endtask

  task automatic test_lock_acquire();
    logic [6:0] cnts [4];
    logic [1:0] sts [4];
    cnts = '{7'd0, 7'd2, 7'd3, 7'd1};
    sts  = '{2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      drive_frame(cnts[i], "acquire");
      n_checks++;
      if (lock_state !== sts[i]) begin
        n_fail++;
        $display("FAIL acquire_state[%0d]: got %0d, expected %0d", i, lock_state, sts[i]);
      end
    end
    n_checks++;
    if (lock !== 1'b1) begin
      n_fail++;
      $display("FAIL acquire_lock: got %0b, expected 1", lock);
    end
  endtask

  task automatic test_broken_confirm();
    logic [6:0] cnts [4];
    logic [1:0] sts [4];
    cnts = '{7'd0, 7'd0, 7'd9, 7'd0};
    sts  = '{2'd1, 2'd1, 2'd0, 2'd1};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive_frame(cnts[i], "broken_confirm");
      n_checks++;
      if (lock_state !== sts[i] || lock !== 1'b0) begin
        n_fail++;
        $display("FAIL broken_confirm[%0d]: got state=%0d lock=%0b, expected state=%0d lock=0",
                 i, lock_state, lock, sts[i]);
      end
    end
  endtask

  task automatic test_flywheel();
    logic [6:0] cnts [6];
    logic [1:0] sts [6];
    cnts = '{7'd20, 7'd20, 7'd0, 7'd20, 7'd20, 7'd20};
    sts  = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd0};
    lock_up();
    for (int i = 0; i < 6; i++) begin
      drive_frame(cnts[i], "flywheel");
      n_checks++;
      if (lock_state !== sts[i]) begin
        n_fail++;
        $display("FAIL flywheel_state[%0d]: got %0d, expected %0d", i, lock_state, sts[i]);
      end
    end
    n_checks++;
    if (lock !== 1'b0) begin
      n_fail++;
      $display("FAIL flywheel_loss_lock: got %0b, expected 0", lock);
    end
  endtask

  task automatic test_window();
    logic [6:0] cnts [8];
    int pulses;
    cnts = '{7'd1, 7'd0, 7'd0, 7'd5, 7'd0, 7'd0, 7'd2, 7'd0};
    pulses = 0;
    lock_up();
    for (int i = 0; i < 8; i++) begin
      drive_frame(cnts[i], "window");
      if (win_done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1 || win_done !== 1'b1 || win_errors !== 13'd8 || win_frame_errors !== 7'd3) begin
      n_fail++;
      $display("FAIL window_totals: got pulses=%0d done=%0b werr=%0d wferr=%0d, expected pulses=1 done=1 werr=8 wferr=3",
               pulses, win_done, win_errors, win_frame_errors);
    end
    idle_cycles(1, "window_pulse_end");
  endtask

  task automatic test_clear();
    logic [23:0] exp;
    logic [23:0] obs;
    drive_frame(7'd2, "pre_clear");
    drive_frame(7'd1, "pre_clear");
    @(negedge clock);
    frame_valid = 1'b1;
    n_clear = 1'b0;
    error_count = 7'd50;
    model_reset();
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1;
    frame_valid = 1'b0;
    n_clear = 1'b1;
    error_count = 7'd104;
    exp = exp_q.pop_front();
    obs = {lock_state, lock, win_done, win_errors, win_frame_errors};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL clear: got state=%0d lock=%0b done=%0b werr=%0d wferr=%0d, expected all 0",
               obs[23:22], obs[21], obs[20], obs[19:7], obs[6:0]);
    end
  endtask

  task automatic test_over_fl();
    for (int i = 0; i < N_GOOD; i++) drive_frame(7'd0, "over_fl_lock");
    drive_frame(7'd104, "over_fl");
    n_checks++;
    if (lock_state !== 2'd3) begin
      n_fail++;
      $display("FAIL over_fl_state: got %0d, expected 3", lock_state);
    end
    drive_frame(7'd0, "over_fl_recover");
    drive_frame(7'd127, "over_fl_max");
  endtask

  task automatic test_reset_mid_window();
    lock_up();
    for (int i = 0; i < WIN; i++) drive_frame(7'd3, "pre_mid_reset");
    for (int i = 0; i < 3; i++) drive_frame(7'd2, "mid_window");
    @(negedge clock);
    #2;
    n_reset = 1'b0;
    #1;
    n_checks++;
    if ({lock_state, lock, win_done, win_errors, win_frame_errors} !== 24'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got state=%0d lock=%0b done=%0b werr=%0d wferr=%0d, expected all 0",
               lock_state, lock, win_done, win_errors, win_frame_errors);
    end
    #1;
    n_reset = 1'b1;
    model_reset();
    drive_frame(7'd0, "after_reset_hunt");
    n_checks++;
    if (lock_state !== 2'd1) begin
      n_fail++;
      $display("FAIL after_reset_state: got %0d, expected 1", lock_state);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       c = $urandom_range(4, 127);
        1:       c = 20;
        default: c = $urandom_range(0, 3);
      endcase
      drive_frame(7'(c), "random");
      if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3), "random_idle");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_lock_acquire();
    test_broken_confirm();
    test_flywheel();
    test_window();
    test_clear();
    test_over_fl();
    test_reset_mid_window();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_ber_monitor.md
FRAME_BER_MONITOR -- requirements
Module: frame_ber_monitor

Interface
REQ-001 SHALL have parameter FL, default 104, meaning frame length in bits (maximum per-frame error count).
REQ-002 SHALL have parameter GOOD_TH, default 3, meaning the largest per-frame error count that still classifies a frame as good.
REQ-003 SHALL have parameter N_GOOD, default 4 (legal range 2..15), meaning consecutive good frames required to declare lock.
REQ-004 SHALL have parameter N_BAD, default 3 (legal range 2..15), meaning consecutive bad frames required to drop lock.
REQ-005 SHALL have parameter WIN, default 64 (legal range 2..64), meaning frames per BER measurement window.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, named as listed below.
REQ-007 SHALL provide `Clock`, input, 1 bit: rising-edge clock.
REQ-008 SHALL provide `nReset`, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL provide `nClear`, input, 1 bit: synchronous active-low clear.
REQ-010 SHALL provide `Frame_Valid`, input, 1 bit: single-cycle strobe; `Error_Count` is valid in that cycle.
REQ-011 SHALL provide `Error_Count`, input, 7 bits: bit errors in the current frame (0..FL).
REQ-012 SHALL provide `Lock`, output, 1 bit: high in LOCKED and FLYWHEEL.
REQ-013 SHALL provide `Lock_State`, output, 2 bits: HUNT=0, CONFIRM=1, LOCKED=2, FLYWHEEL=3.
REQ-014 SHALL provide `Win_Errors`, output, 13 bits: total bit errors in the last completed window.
REQ-015 SHALL provide `Win_Frame_Errors`, output, 7 bits: frames with `Error_Count`≠0 in the last completed window.
REQ-016 SHALL provide `Win_Done`, output, 1 bit: one-cycle pulse when the window outputs update.

Function
REQ-017 SHALL classify a frame as good when `Error_Count` ≤ GOOD_TH and as bad otherwise; any value > FL is also bad.
REQ-018 SHALL act only on cycles where `Frame_Valid`=1; state, counters and outputs hold on all other cycles.
REQ-019 SHALL update state and counters on the rising edge that samples `Frame_Valid`=1; updated outputs are visible from the next cycle (1-cycle latency).
REQ-020 SHALL apply these transitions from HUNT: a good frame goes to CONFIRM with run count 1; a bad frame stays in HUNT.
REQ-021 SHALL apply these transitions from CONFIRM: a good frame increments the run count and goes to LOCKED when the count reaches N_GOOD; a bad frame goes to HUNT and zeroes the run count.
REQ-022 SHALL apply these transitions from LOCKED: a bad frame goes to FLYWHEEL with run count 1; a good frame stays in LOCKED.
REQ-023 SHALL apply these transitions from FLYWHEEL: a bad frame increments the run count and goes to HUNT when the count reaches N_BAD; a good frame goes to LOCKED and zeroes the run count.
REQ-024 SHALL accumulate window statistics only for frames sampled while `Lock`=1 before the edge, including the frame that causes the exit from FLYWHEEL.
REQ-025 SHALL count window frames 0..WIN-1; on the WIN-th accumulated frame it SHALL load `Win_Errors`/`Win_Frame_Errors` with totals including that frame, pulse `Win_Done` for exactly one cycle, and restart the accumulators at 0.
REQ-026 SHALL discard the partial window (accumulators and frame counter to 0) on any transition into HUNT; `Win_Errors`/`Win_Frame_Errors` keep their last completed values.
REQ-027 SHALL size accumulators so that WIN=64 with FL=104 per frame (6656) never overflows; no saturation logic is required within legal parameters.
REQ-028 SHALL give `nClear`=0 priority over `Frame_Valid`, returning every register to its reset value on that edge.
REQ-029 SHALL assert `Win_Done` only in the cycle after the completing frame, never on consecutive cycles.

Reset
REQ-030 SHALL, while `nReset`=0, immediately force `Lock_State`=HUNT, `Lock`=0, `Win_Errors`=0, `Win_Frame_Errors`=0, `Win_Done`=0, and all internal counters to 0.
REQ-031 SHALL, on reset asserted mid-window or mid-pulse, abort without completing the window; after release the first `Frame_Valid` is treated as a HUNT frame.

Verification (GOOD_TH=3, N_GOOD=4, N_BAD=3, WIN=8)
REQ-032 SHALL cover lock acquisition: counts 0,2,3,1 → `Lock_State` 1,1,1,2; `Lock`=1 one cycle after the 4th strobe.
REQ-033 SHALL cover a broken confirm: counts 0,0,9,0 → states 1,1,0,1; `Lock` never asserted.
REQ-034 SHALL cover flywheel recovery and loss: when LOCKED, counts 20,20,0 → 3,3,2; then 20,20,20 → 3,3,0, `Lock`=0.
REQ-035 SHALL cover a full window: when LOCKED, 8 frames of count 1,0,0,5,0,0,2,0 → single `Win_Done` pulse with `Win_Errors`=8 and `Win_Frame_Errors`=3 (count 5 also drops to FLYWHEEL then recovers).
REQ-036 SHALL cover clear and reset: `nClear`=0 coincident with `Frame_Valid` → all outputs 0, state HUNT; `nReset` pulse mid-window → outputs 0 immediately, no `Win_Done`.
REQ-037 SHALL cover the cleared input: `Error_Count`=104 (post-clear value) in LOCKED → treated as bad, state goes to FLYWHEEL.
